// File: rtl/dds_pkg.sv
// dds_pkg: constants shared by the DDS front-panel logic.
//   DDS_WIDTH / DDS_N_STEPS      : tuning word width and number of button pairs
//   DDS_STEP_SIZES               : packed increments, pair 0 (coarsest) in the most significant slot
//   DDS_MIN/MAX/INIT_WORD        : clamp bounds and power-up tuning word
//   *_CYCLES                     : button timing derived from the system clock frequency
//   step_dir_e                   : direction chosen by the arbiter in a given cycle
//   slot_of()                    : maps a pair index to its slot in DDS_STEP_SIZES
package dds_pkg;

    localparam int DDS_WIDTH   = 32;
    localparam int DDS_N_STEPS = 3;

    localparam logic [DDS_WIDTH*DDS_N_STEPS-1:0] DDS_STEP_SIZES = {32'd10000, 32'd1000, 32'd1};

    localparam logic [DDS_WIDTH-1:0] DDS_MIN_WORD  = 32'd10000;
    localparam logic [DDS_WIDTH-1:0] DDS_MAX_WORD  = 32'd2000000;
    localparam logic [DDS_WIDTH-1:0] DDS_INIT_WORD = 32'd1000000;

    localparam int CLK_FREQ_HZ          = 50_000_000;
    localparam int DEBOUNCE_CYCLES      = CLK_FREQ_HZ / 200;  // 5 ms
    localparam int HOLD_CYCLES_DEFAULT  = CLK_FREQ_HZ / 2;    // 0.5 s before auto-repeat
    localparam int REPEAT_CYCLES_DEFAULT = CLK_FREQ_HZ / 20;  // 50 ms between repeats

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } step_dir_e;

    // Pair 0 is the coarsest and sits in the most significant slot of the packed table.
    function automatic int slot_of(input int idx, input int n_steps);
        return n_steps - 1 - idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: one raw active-low push button -> debounced level plus event pulses.
//   clk     in  system clock
//   reset   in  synchronous, active-low reset
//   RawN    in  raw button, 0 = pressed, asynchronous to clk
//   Pressed out debounced level, 1 = pressed
//   Event   out one-cycle pulse on a new press and on every auto-repeat tick while held
module button_debouncer #(
    parameter int DEBOUNCE      = 250000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 2500000
) (
    input  logic clk,
    input  logic reset,
    input  logic RawN,
    output logic Pressed,
    output logic Event
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          repeating_q, repeating_d;
    logic          event_q, event_d;
    logic          sample_pressed;

    always_comb begin
        sync1_d        = RawN;
        sync2_d        = sync1_q;
        sample_pressed = ~sync2_q;

        // Count consecutive samples that disagree with the accepted level; any
        // agreeing sample restarts the count, so only a stable change gets through.
        level_d  = level_q;
        db_cnt_d = '0;
        if (sample_pressed != level_q) begin
            if (db_cnt_q == DW'(DEBOUNCE - 1)) begin
                level_d = sample_pressed;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        // Timers only run while the button stays pressed; the release edge
        // itself clears them and never produces a repeat.
        event_d     = 1'b0;
        hold_cnt_d  = '0;
        rep_cnt_d   = '0;
        repeating_d = 1'b0;
        if (level_d && !level_q) begin
            event_d = 1'b1;
        end else if (level_d && level_q) begin
            hold_cnt_d  = hold_cnt_q;
            rep_cnt_d   = rep_cnt_q;
            repeating_d = repeating_q;
            if (!repeating_q) begin
                if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                    event_d     = 1'b1;
                    repeating_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end else begin
                if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
                    event_d   = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            level_q     <= 1'b0;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rep_cnt_q   <= '0;
            repeating_q <= 1'b0;
            event_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            repeating_q <= repeating_d;
            event_q     <= event_d;
        end
    end

    assign Pressed = level_q;
    assign Event   = event_q;

endmodule

// File: rtl/tuning_word_controller.sv
// tuning_word_controller: DDS tuning word driven by N_STEPS up/down button pairs.
//   clk          in  system clock
//   reset        in  synchronous, active-low reset
//   SwitchUp     in  raw up buttons, active-low, index 0 = coarsest
//   SwitchDown   in  raw down buttons, active-low
//   Step         out current tuning word, saturated to [MIN_WORD, MAX_WORD]
//   StepChanged  out one-cycle pulse in the cycle Step takes a new value
//   AtMin/AtMax  out Step sits on the lower/upper clamp
module tuning_word_controller
    import dds_pkg::*;
#(
    parameter int                         WIDTH         = DDS_WIDTH,
    parameter int                         N_STEPS       = DDS_N_STEPS,
    parameter logic [WIDTH*N_STEPS-1:0]   STEP_SIZES    = DDS_STEP_SIZES,
    parameter logic [WIDTH-1:0]           MIN_WORD      = DDS_MIN_WORD,
    parameter logic [WIDTH-1:0]           MAX_WORD      = DDS_MAX_WORD,
    parameter logic [WIDTH-1:0]           INIT_WORD     = DDS_INIT_WORD,
    parameter int                         DEBOUNCE      = DEBOUNCE_CYCLES,
    parameter int                         HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int                         REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_STEPS-1:0] SwitchUp,
    input  logic [N_STEPS-1:0] SwitchDown,
    output logic [WIDTH-1:0]   Step,
    output logic               StepChanged,
    output logic               AtMin,
    output logic               AtMax
);

    logic [N_STEPS-1:0] up_event, dn_event;
    logic [N_STEPS-1:0] up_pressed, dn_pressed;
    logic [WIDTH-1:0]   step_size [N_STEPS];

    genvar gi;
    generate
        for (gi = 0; gi < N_STEPS; gi++) begin : g_pair
            button_debouncer #(
                .DEBOUNCE     (DEBOUNCE),
                .HOLD_CYCLES  (HOLD_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES)
            ) u_up (
                .clk    (clk),
                .reset  (reset),
                .RawN   (SwitchUp[gi]),
                .Pressed(up_pressed[gi]),
                .Event  (up_event[gi])
            );

            button_debouncer #(
                .DEBOUNCE     (DEBOUNCE),
                .HOLD_CYCLES  (HOLD_CYCLES),
                .REPEAT_CYCLES(REPEAT_CYCLES)
            ) u_dn (
                .clk    (clk),
                .reset  (reset),
                .RawN   (SwitchDown[gi]),
                .Pressed(dn_pressed[gi]),
                .Event  (dn_event[gi])
            );

            assign step_size[gi] = STEP_SIZES[slot_of(gi, N_STEPS)*WIDTH +: WIDTH];
        end
    endgenerate

    logic [WIDTH-1:0]   step_q, step_d;
    logic               step_changed_q, step_changed_d;
    logic               at_min_q, at_min_d;
    logic               at_max_q, at_max_d;
    logic [N_STEPS-1:0] up_valid, dn_valid;
    step_dir_e          dir_sel;
    logic [WIDTH-1:0]   inc;
    logic [WIDTH:0]     sum_wide, floor_wide;
    logic [WIDTH-1:0]   next_word;

    always_comb begin
        up_valid = up_event & up_pressed;
        dn_valid = dn_event & dn_pressed;

        // Walk from finest to coarsest so the lowest-index pair is written last
        // and wins; a pair with both directions at once cancels itself out.
        dir_sel = DIR_NONE;
        inc     = '0;
        for (int i = N_STEPS - 1; i >= 0; i--) begin
            if (up_valid[i] != dn_valid[i]) begin
                dir_sel = up_valid[i] ? DIR_UP : DIR_DOWN;
                inc     = step_size[i];
            end
        end

        // One extra bit keeps the overflow/underflow tests exact.
        sum_wide   = {1'b0, step_q} + {1'b0, inc};
        floor_wide = {1'b0, MIN_WORD} + {1'b0, inc};
        next_word  = step_q;
        case (dir_sel)
            DIR_UP:   next_word = (sum_wide > {1'b0, MAX_WORD}) ? MAX_WORD : sum_wide[WIDTH-1:0];
            DIR_DOWN: next_word = ({1'b0, step_q} < floor_wide) ? MIN_WORD : (step_q - inc);
            default:  next_word = step_q;
        endcase

        step_d         = next_word;
        step_changed_d = (next_word != step_q);
        at_min_d       = (next_word == MIN_WORD);
        at_max_d       = (next_word == MAX_WORD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            step_q         <= INIT_WORD;
            step_changed_q <= 1'b0;
            at_min_q       <= (INIT_WORD == MIN_WORD);
            at_max_q       <= (INIT_WORD == MAX_WORD);
        end else begin
            step_q         <= step_d;
            step_changed_q <= step_changed_d;
            at_min_q       <= at_min_d;
            at_max_q       <= at_max_d;
        end
    end

    assign Step        = step_q;
    assign StepChanged = step_changed_q;
    assign AtMin       = at_min_q;
    assign AtMax       = at_max_q;

endmodule

// File: tb/tb_tuning_word_controller.sv
// Bench for tuning_word_controller with short button timing
// (DEBOUNCE=4, HOLD_CYCLES=20, REPEAT_CYCLES=5).
module tb_tuning_word_controller;

    localparam int     NS    = 3;
    localparam int     NB    = 2 * NS;
    localparam int     D     = 4;
    localparam int     H     = 20;
    localparam int     R     = 5;
    localparam longint MINW  = 10000;
    localparam longint MAXW  = 2000000;
    localparam longint INITW = 1000000;
    localparam int     MAXC  = 4096;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NS-1:0] sw_up = '1;
    logic [NS-1:0] sw_dn = '1;
    logic [31:0]   step;
    logic          step_changed;
    logic          at_min;
    logic          at_max;

    int vectors     = 0;
    int miscompares = 0;

    tuning_word_controller #(
        .DEBOUNCE     (D),
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .SwitchUp   (sw_up),
        .SwitchDown (sw_dn),
        .Step       (step),
        .StepChanged(step_changed),
        .AtMin      (at_min),
        .AtMax      (at_max)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Buttons 0..NS-1 are Up pairs, NS..NB-1 are Down pairs.
    longint        inc_of [NS] = '{10000, 1000, 1};
    logic [NB-1:0] raw_log [MAXC];
    int            cyc      = 0;
    int            last_rst = -100;
    bit [NB-1:0]   lvl      = '0;
    int            acc_t [NB];
    bit [NB-1:0]   ev_prev  = '0;
    longint        m_step   = INITW;
    bit            m_changed = 1'b0;
    int            pulse_total = 0;
    bit            check_en = 1'b0;

    // Raw level seen by the debounce stage at edge t: two edges of synchroniser
    // delay, and anything from before/at a reset edge reads as released.
    function automatic bit released_at(input int b, input int t);
        if (t - 2 <= last_rst) return 1'b1;
        return raw_log[(t - 2) % MAXC][b];
    endfunction

    task automatic model_edge();
        logic [NB-1:0] ev;
        bit            nl;
        bit            all_diff;
        bit            found;
        int            k;
        longint        nxt;
        raw_log[cyc % MAXC] = {sw_dn, sw_up};
        if (!reset) begin
            last_rst  = cyc;
            m_step    = INITW;
            m_changed = 1'b0;
            lvl       = '0;
            ev_prev   = '0;
        end else begin
            m_changed = 1'b0;
            found     = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (!found && (ev_prev[i] != ev_prev[NS+i])) begin
                    found = 1'b1;
                    if (ev_prev[i]) nxt = (m_step + inc_of[i] > MAXW) ? MAXW : m_step + inc_of[i];
                    else            nxt = (m_step < MINW + inc_of[i]) ? MINW : m_step - inc_of[i];
                    m_changed = (nxt != m_step);
                    m_step    = nxt;
                end
            end
            ev = '0;
            for (int b = 0; b < NB; b++) begin
                nl = lvl[b];
                if (cyc - D + 1 > last_rst) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (!released_at(b, cyc - j) == lvl[b]) all_diff = 1'b0;
                    if (all_diff) nl = ~lvl[b];
                end
                if (nl && !lvl[b]) begin
                    ev[b]    = 1'b1;
                    acc_t[b] = cyc;
                end else if (nl && lvl[b]) begin
                    k = cyc - acc_t[b];
                    if (k == H || (k > H && (k - H) % R == 0)) ev[b] = 1'b1;
                end
                lvl[b] = nl;
            end
            ev_prev = ev;
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (step_changed === 1'b1) pulse_total++;
        if (check_en) begin
            vectors++;
            if (step !== m_step[31:0] || step_changed !== m_changed ||
                at_min !== (m_step == MINW) || at_max !== (m_step == MAXW)) begin
                miscompares++;
                $display("FAIL model cycle %0d: dut step=%0d chg=%b min=%b max=%b, want step=%0d chg=%b min=%b max=%b",
                         cyc, step, step_changed, at_min, at_max, m_step, m_changed,
                         m_step == MINW, m_step == MAXW);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic expect_eq(input string what, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", what, got, want);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // Hold the masked buttons for len cycles, release, let everything settle.
    task automatic press(input logic [NS-1:0] up_m, input logic [NS-1:0] dn_m,
                         input int len, output int pulses);
        int p0;
        p0    = pulse_total;
        sw_up = ~up_m;
        sw_dn = ~dn_m;
        repeat (len) @(negedge clk);
        sw_up = '1;
        sw_dn = '1;
        repeat (14) @(negedge clk);
        pulses = pulse_total - p0;
    endtask

    // Hold length that produces exactly n events (1 press + n-1 repeats).
    function automatic int len_for(input int n);
        return (n == 1) ? 8 : H + (n - 2) * R + 1;
    endfunction

    typedef struct {
        logic [NS-1:0] up_m;
        logic [NS-1:0] dn_m;
        int            len;
        longint        exp_step;
        int            exp_pulses;
    } vec_t;

    vec_t tab [8];

    initial begin
        int p;
        int p0;
        int found;

        tab[0] = '{3'b100, 3'b000, 40, 1000005, 5};  // hold fine up: press + 4 repeats
        tab[1] = '{3'b001, 3'b000,  8, 1010005, 1};
        tab[2] = '{3'b000, 3'b010,  8, 1009005, 1};
        tab[3] = '{3'b010, 3'b010,  8, 1009005, 0};  // same pair both ways: ignored
        tab[4] = '{3'b001, 3'b100,  8, 1019005, 1};  // coarse up beats fine down
        tab[5] = '{3'b000, 3'b001, 26,  989005, 3};
        tab[6] = '{3'b110, 3'b000,  8,  990005, 1};  // pair 1 beats pair 2
        tab[7] = '{3'b000, 3'b100, 21,  990003, 2};

        // Reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        expect_eq("reset Step", step, INITW);
        expect_eq("reset StepChanged", step_changed, 0);
        expect_eq("reset AtMin", at_min, 0);
        expect_eq("reset AtMax", at_max, 0);
        reset    = 1'b1;
        check_en = 1'b1;

        // Bounce then a clean press
        p0 = pulse_total;
        for (int i = 0; i < 10; i++) begin
            sw_up[0] = ~sw_up[0];
            repeat (2) @(negedge clk);
        end
        press(3'b001, 3'b000, 10, p);
        expect_eq("bounce pulses", pulse_total - p0, 1);
        expect_eq("bounce Step", step, 1010000);

        // Table of single presses / holds / conflicts
        do_reset();
        for (int i = 0; i < 8; i++) begin
            press(tab[i].up_m, tab[i].dn_m, tab[i].len, p);
            expect_eq($sformatf("vec%0d Step", i), step, tab[i].exp_step);
            expect_eq($sformatf("vec%0d pulses", i), p, tab[i].exp_pulses);
        end

        // Clamp at MAX
        do_reset();
        press(3'b001, 3'b000, len_for(99), p);
        press(3'b010, 3'b000, len_for(5), p);
        expect_eq("pre-max Step", step, 1995000);
        press(3'b001, 3'b000, 8, p);
        expect_eq("max Step", step, MAXW);
        expect_eq("max AtMax", at_max, 1);
        expect_eq("max pulses", p, 1);
        press(3'b001, 3'b000, 8, p);
        expect_eq("max again Step", step, MAXW);
        expect_eq("max again pulses", p, 0);

        // Clamp at MIN
        press(3'b000, 3'b001, len_for(198), p);
        press(3'b000, 3'b010, len_for(5), p);
        expect_eq("pre-min Step", step, 15000);
        expect_eq("pre-min AtMin", at_min, 0);
        press(3'b000, 3'b001, 8, p);
        expect_eq("min Step", step, MINW);
        expect_eq("min AtMin", at_min, 1);
        expect_eq("min pulses", p, 1);
        press(3'b000, 3'b001, 8, p);
        expect_eq("min again Step", step, MINW);
        expect_eq("min again pulses", p, 0);

        // Reset while a button is held in auto-repeat
        do_reset();
        sw_dn[1] = 1'b0;
        repeat (30) @(negedge clk);
        expect_eq("hold before reset Step", step, 998000);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        expect_eq("mid-hold reset Step", step, INITW);
        expect_eq("mid-hold reset StepChanged", step_changed, 0);
        found = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (step_changed === 1'b1 && found == 0) found = i;
        end
        expect_eq("cycles reset->change", found, D + 3);
        expect_eq("after re-press Step", step, 999000);
        sw_dn = '1;
        repeat (14) @(negedge clk);

        // Randomised buttons (with occasional resets) against the model
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(11) == 0) begin
                for (int b = 0; b < NS; b++) begin
                    sw_up[b] = ($urandom_range(3) != 0);
                    sw_dn[b] = ($urandom_range(3) != 0);
                end
            end
            reset = ($urandom_range(399) != 0);
            @(negedge clk);
        end
        reset = 1'b1;
        sw_up = '1;
        sw_dn = '1;
        repeat (14) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
